// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a small prefetch FIFO between the
// instruction memory and ID.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   branch_addr/_taken    - redirect from MEM (highest priority)
//   jump_addr/is_jump     - redirect from ID
//   stall_pipeline        - ID holds its input; output register frozen
//   imem_en/addr/data     - instruction memory, data valid one cycle after en
//   instruction/pc/valid  - registered fetch result to ID
//   buf_count             - prefetch FIFO occupancy (0..DEPTH)
module if_prefetch_stage #(
    parameter int PC_WIDTH = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PC_WIDTH-1:0]          branch_addr,
    input  logic                         branch_taken,
    input  logic [PC_WIDTH-1:0]          jump_addr,
    input  logic                         is_jump,
    input  logic                         stall_pipeline,
    output logic                         imem_en,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         valid,
    output logic [$clog2(DEPTH):0]       buf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc;
    logic                inflight;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;

    logic [PC_WIDTH-1:0]          buf_pc  [DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] buf_ins [DEPTH];

    logic                redirect;
    logic [PC_WIDTH-1:0] target;
    logic                push;
    logic                pop;
    logic                bypass;
    logic                wr;

    assign redirect = branch_taken | is_jump;
    assign target   = branch_taken ? branch_addr : jump_addr;

    // Returning read data; a redirect this cycle kills it.
    assign push = inflight & ~redirect;

    assign pop = ~redirect & ~stall_pipeline & (buf_count != '0);

    // Empty FIFO: hand the returning word straight to the output.
    assign bypass = ~redirect & ~stall_pipeline
                  & (buf_count == '0) & push;

    assign wr = push & ~bypass;

    // Reserve a slot for the read in flight so a push always fits.
    assign imem_en = ~rst & ~redirect
                   & ((buf_count + CW'(inflight)) < FULL);

    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            buf_count   <= '0;
            instruction <= NOP_INSTRUCTION;
            pc          <= '0;
            valid       <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= target;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            buf_count   <= '0;
            instruction <= NOP_INSTRUCTION;
            valid       <= 1'b0;
        end else begin
            inflight    <= imem_en;
            inflight_pc <= fetch_pc;
            if (imem_en) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(1);
            end
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            buf_count <= buf_count + CW'(wr) - CW'(pop);
            if (!stall_pipeline) begin
                if (pop) begin
                    instruction <= buf_ins[rd_ptr];
                    pc          <= buf_pc[rd_ptr];
                    valid       <= 1'b1;
                end else if (bypass) begin
                    instruction <= imem_data;
                    pc          <= inflight_pc;
                    valid       <= 1'b1;
                end else begin
                    instruction <= NOP_INSTRUCTION;
                    valid       <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            buf_pc[wr_ptr]  <= inflight_pc;
            buf_ins[wr_ptr] <= imem_data;
        end
    end

endmodule
